step_pattern_sequencer: RTL and testbench

Consumes press events from the 4x4 button matrix controller (`button_index` and `button_pressed`) and turns them into a 16-step on/off pattern. Each distinct physical press toggles exactly one step. A free-running tempo counter walks a playhead across the 16 steps and emits a fixed-width gate pulse on every active step. It sits directly downstream of the matrix scanner and feeds the audio/trigger output stage and the LED display.

---
 rtl/step_pattern_sequencer.sv | 112 +++++++++++
 tb/tb_step_pattern_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/step_pattern_sequencer.sv
// 16-step on/off pattern sequencer: key presses toggle steps, a tempo
// counter walks the playhead and fires a fixed-width gate on active steps.
module step_pattern_sequencer #(
  parameter int TICKS_PER_STEP = 12_500_000,
  parameter int GATE_TICKS     = 1_000_000,
  parameter int RELEASE_TICKS  = 200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button_pressed,
  input  logic [3:0]  button_index,
  input  logic        run,
  output logic [15:0] pattern,
  output logic [3:0]  step,
  output logic        step_start,
  output logic        gate,
  output logic        toggle_strobe
);

  localparam int TW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int RW = (RELEASE_TICKS > 2) ? $clog2(RELEASE_TICKS) : 1;
  // one extra code point so the counter can hold GATE_TICKS itself
  localparam int GW = $clog2(GATE_TICKS + 1);

  typedef enum logic {IDLE, HELD} press_t;

  press_t          state, state_nx;
  logic [RW-1:0]   rel_cnt, rel_nx;
  logic            do_toggle;
  logic [TW-1:0]   tick;
  logic [GW-1:0]   gate_cnt;
  logic            run_q;

  always_comb begin
    state_nx  = state;
    rel_nx    = rel_cnt;
    do_toggle = 1'b0;
    unique case (state)
      IDLE: begin
        if (button_pressed) begin
          do_toggle = 1'b1;
          rel_nx    = '0;
          state_nx  = HELD;
        end
      end
      HELD: begin
        if (button_pressed) begin
          rel_nx = '0;
        end else if (rel_cnt == RW'(RELEASE_TICKS - 1)) begin
          rel_nx   = '0;
          state_nx = IDLE;
        end else begin
          rel_nx = rel_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rel_cnt       <= '0;
      pattern       <= '0;
      toggle_strobe <= 1'b0;
    end else begin
      state         <= state_nx;
      rel_cnt       <= rel_nx;
      toggle_strobe <= do_toggle;
      if (do_toggle)
        pattern[button_index] <= ~pattern[button_index];
    end
  end

  // gate decision sees the registered pattern, so a same-cycle toggle
  // only affects the next visit of that step
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      tick       <= '0;
      step       <= '0;
      step_start <= 1'b0;
      gate_cnt   <= '0;
    end else begin
      run_q      <= run;
      step_start <= 1'b0;
      if (!run) begin
        tick     <= '0;
        step     <= '0;
        gate_cnt <= '0;
      end else begin
        if (step_start && pattern[step])
          gate_cnt <= GW'(GATE_TICKS);
        else if (gate_cnt != '0)
          gate_cnt <= gate_cnt - 1'b1;
        if (!run_q) begin
          tick       <= '0;
          step       <= '0;
          step_start <= 1'b1;
        end else if (tick == TW'(TICKS_PER_STEP - 1)) begin
          tick       <= '0;
          step       <= step + 4'd1;
          step_start <= 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  assign gate = (gate_cnt != '0);

endmodule

// File: tb/tb_step_pattern_sequencer.sv
// Scoreboard bench for step_pattern_sequencer: a time-based reference
// model queues expected outputs per edge, a monitor pops and compares.
module tb_step_pattern_sequencer;

  localparam int T = 8;
  localparam int G = 3;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button_pressed = 1'b0;
  logic [3:0]  button_index = 4'd0;
  logic        run = 1'b0;
  logic [15:0] pattern;
  logic [3:0]  step;
  logic        step_start;
  logic        gate;
  logic        toggle_strobe;

  always #5 clk = ~clk;

  step_pattern_sequencer #(
    .TICKS_PER_STEP(T),
    .GATE_TICKS(G),
    .RELEASE_TICKS(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_pressed(button_pressed),
    .button_index(button_index),
    .run(run),
    .pattern(pattern),
    .step(step),
    .step_start(step_start),
    .gate(gate),
    .toggle_strobe(toggle_strobe)
  );

  typedef struct packed {
    logic [15:0] pat;
    logic [3:0]  stp;
    logic        ss;
    logic        gt;
    logic        strobe;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  int last_hi = -1;
  int run_start = -1;
  int strobes = 0;
  logic [15:0] m_pat = '0;
  logic gbit = 1'b0;

  // Model: a press is accepted iff at least R low samples separate it from
  // the previous press sample; playback derived from edges since run start.
  always @(posedge clk) begin
    exp_t e;
    int k;
    e = '0;
    if (rst) begin
      m_pat = '0;
      last_hi = -1;
      run_start = -1;
      gbit = 1'b0;
    end else begin
      if (button_pressed) begin
        if (last_hi < 0 || n - last_hi - 1 >= R) begin
          m_pat[button_index] = ~m_pat[button_index];
          e.strobe = 1'b1;
        end
        last_hi = n;
      end
      if (!run) begin
        run_start = -1;
      end else begin
        if (run_start < 0) run_start = n;
        k = n - run_start;
        e.ss = (k % T == 0);
        e.stp = 4'((k / T) % 16);
        if (k >= 1 && (k - 1) % T < G) e.gt = gbit;
        if (e.ss) gbit = m_pat[e.stp];
      end
    end
    e.pat = m_pat;
    q.push_back(e);
    n++;
  end

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %h, expected %h", nm, n, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (toggle_strobe) strobes++;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("pattern", pattern, e.pat);
      cmp("step", 16'(step), 16'(e.stp));
      cmp("step_start", 16'(step_start), 16'(e.ss));
      cmp("gate", 16'(gate), 16'(e.gt));
      cmp("toggle_strobe", 16'(toggle_strobe), 16'(e.strobe));
    end
  end

  task automatic drive(input bit p, input logic [3:0] idx,
                       input bit r, input bit rs);
    @(negedge clk);
    button_pressed = p;
    button_index = idx;
    run = r;
    rst = rs;
  endtask

  task automatic press_key(input logic [3:0] idx);
    drive(1, idx, 0, 0);
    repeat (5) drive(0, 4'd0, 0, 0);
  endtask

  initial begin
    int burst;
    logic [3:0] key;
    bit run_r;
    repeat (2) drive(0, 4'd0, 0, 1);
    drive(0, 4'd0, 0, 0);
    cmp("reset_pattern", pattern, 16'h0000);
    cmp("reset_gate", 16'(gate), 16'h0000);

    for (int c = 0; c < 20; c++) drive(c % 4 == 0, 4'd5, 0, 0);
    repeat (10) drive(0, 4'd0, 0, 0);
    cmp("single_press_pattern", pattern, 16'h0020);
    cmp("single_press_strobes", 16'(strobes), 16'd1);

    for (int c = 0; c < 20; c++) drive(c % 4 == 0, 4'd5, 0, 0);
    repeat (10) drive(0, 4'd0, 0, 0);
    cmp("second_press_pattern", pattern, 16'h0000);
    cmp("second_press_strobes", 16'(strobes), 16'd2);

    for (int c = 0; c < 16; c++)
      drive(c % 2 == 0, (c % 4 == 0) ? 4'd3 : 4'd9, 0, 0);
    repeat (10) drive(0, 4'd0, 0, 0);
    cmp("held_other_ignored", pattern, 16'h0008);

    press_key(4'd3);
    press_key(4'd0);
    press_key(4'd2);
    cmp("playback_pattern", pattern, 16'h0005);

    repeat (170) drive(0, 4'd0, 1, 0);
    drive(0, 4'd0, 0, 0);
    drive(0, 4'd0, 0, 0);
    cmp("stop_step", 16'(step), 16'h0000);
    cmp("stop_gate", 16'(gate), 16'h0000);
    cmp("stop_pattern", pattern, 16'h0005);

    for (int k = 0; k < 2 * T + 2; k++) drive(k == T + 1, 4'd1, 1, 0);
    drive(0, 4'd0, 1, 1);
    cmp("collision_pattern", pattern, 16'h0007);
    cmp("midgate_gate", 16'(gate), 16'h0001);
    drive(0, 4'd0, 0, 0);
    cmp("rst_pattern", pattern, 16'h0000);
    cmp("rst_gate", 16'(gate), 16'h0000);
    cmp("rst_step", 16'(step), 16'h0000);

    burst = 0;
    key = 4'd0;
    run_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) run_r = ~run_r;
      if (burst == 0 && $urandom_range(0, 19) == 0) begin
        burst = $urandom_range(1, 15);
        key = 4'($urandom);
      end
      drive(burst > 0 && $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : key,
            run_r, $urandom_range(0, 599) == 0);
      if (burst > 0) burst--;
    end
    repeat (3) drive(0, 4'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
